// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, imem address, IF/ID register.
// Redirect support and misaligned/out-of-range fetch fault with halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_fault
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] word_idx;
    logic        fault_now;
    logic        load;

    assign imem_addr = {2'b00, pc[31:2]};
    assign word_idx  = {2'b00, pc[31:2]};
    assign pc_next   = pc + 32'd4;

    assign fault_now = (pc[1:0] != 2'b00)
                     | (word_idx >= IMEM_WORDS);

    assign load = (state == RUN)
                & (~id_valid | id_ready);

    // PC, halt FSM and IF/ID register, redirect first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            state       <= RUN;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= 32'h0;
            id_pc_plus4 <= 32'h0;
            id_fault    <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
            state    <= RUN;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus4 <= pc_next;
            id_fault    <= fault_now;
            if (fault_now) begin
                id_instr <= NOP_INSTR;
                state    <= HALT;
            end else begin
                id_instr <= imem_instr;
                pc       <= pc_next;
            end
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps plus random
// ready/redirect traffic against a word-stream reference model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    // reference model: address of next word the stream must deliver
    logic [31:0] exp_pc;
    bit          halted;
    bit          fresh;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_fault       (id_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_instr = (imem_addr < 32'd256)
                      ? mem[imem_addr[7:0]]
                      : 32'hDEAD_BEEF;

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= 256);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (is_fault(a))
            return 32'h0000_0013;
        return mem[a / 4];
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc = 32'h0;
        halted = 0;
        fresh  = 1;
    endtask

    // drive one cycle's inputs at negedge, advance model, check after edge
    task automatic cycle(input logic rdy,
                         input logic rv,
                         input logic [31:0] rpc);
        bit exp_valid;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) begin
            exp_pc = rpc;
            halted = 0;
            fresh  = 1;
        end else begin
            if (id_valid && rdy) begin
                if (is_fault(exp_pc))
                    halted = 1;
                else
                    exp_pc = exp_pc + 32'd4;
            end
            fresh = 0;
        end
        @(posedge clk);
        @(negedge clk);
        exp_valid = !fresh && !halted;
        chk("model_valid", {31'b0, id_valid}, {31'b0, exp_valid});
        if (id_valid && exp_valid) begin
            chk("model_pc", id_pc, exp_pc);
            chk("model_pc4", id_pc_plus4, exp_pc + 32'd4);
            chk("model_fault", {31'b0, id_fault},
                {31'b0, is_fault(exp_pc)});
            chk("model_instr", id_instr, exp_word(exp_pc));
        end
    endtask

    initial begin
        int kind;
        logic [31:0] tgt;
        logic rdy;
        logic rv;

        for (int i = 0; i < 256; i++)
            mem[i] = 32'h1000 + i;
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();

        // 1. reset values, then back-to-back fetch
        #23;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h13);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_fault", {31'b0, id_fault}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0);
        chk("t1_pc0", id_pc, 32'h0);
        chk("t1_i0", id_instr, 32'h1000);
        cycle(1, 0, 0);
        chk("t1_pc4", id_pc, 32'h4);
        chk("t1_i1", id_instr, 32'h1001);
        cycle(1, 0, 0);
        chk("t1_pc8", id_pc, 32'h8);
        chk("t1_i2", id_instr, 32'h1002);

        // 2. stall with id_pc=4 held
        cycle(0, 1, 32'h4);
        cycle(0, 0, 0);
        chk("t2_pc", id_pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            chk("t2_hold_pc", id_pc, 32'h4);
            chk("t2_hold_i", id_instr, 32'h1001);
            chk("t2_addr", imem_addr, 32'h2);
        end
        cycle(1, 0, 0);
        chk("t2_next", id_pc, 32'h8);
        chk("t2_next_i", id_instr, 32'h1002);

        // 3. redirect while stalled
        cycle(0, 1, 32'h40);
        chk("t3_valid", {31'b0, id_valid}, 32'h0);
        chk("t3_addr", imem_addr, 32'd16);
        cycle(1, 0, 0);
        chk("t3_pc", id_pc, 32'h40);
        chk("t3_i", id_instr, 32'h1010);

        // 4. run off the end of memory
        cycle(1, 1, 32'h3F8);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("t4_last", id_pc, 32'h3FC);
        cycle(1, 0, 0);
        chk("t4_pc", id_pc, 32'h400);
        chk("t4_fault", {31'b0, id_fault}, 32'h1);
        chk("t4_nop", id_instr, 32'h13);
        cycle(1, 0, 0);
        chk("t4_halt", {31'b0, id_valid}, 32'h0);
        cycle(1, 0, 0);
        chk("t4_halt2", {31'b0, id_valid}, 32'h0);
        chk("t4_addr", imem_addr, 32'd256);
        cycle(1, 1, 32'h10);
        cycle(1, 0, 0);
        chk("t4_resume", id_pc, 32'h10);
        chk("t4_nofault", {31'b0, id_fault}, 32'h0);

        // 5. misaligned redirect, then wrap of pc+4
        cycle(1, 1, 32'h6);
        cycle(1, 0, 0);
        chk("t5_pc", id_pc, 32'h6);
        chk("t5_fault", {31'b0, id_fault}, 32'h1);
        cycle(1, 0, 0);
        chk("t5_halt", {31'b0, id_valid}, 32'h0);
        cycle(1, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        chk("wrap_pc4", id_pc_plus4, 32'h0);
        chk("wrap_fault", {31'b0, id_fault}, 32'h1);

        // random traffic with fresh memory contents
        cycle(1, 1, 32'h0);
        for (int i = 0; i < 256; i++)
            mem[i] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = halted ? ($urandom_range(0, 9) < 4)
                         : ($urandom_range(0, 99) < 6);
            kind = $urandom_range(0, 9);
            if (kind < 6)
                tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            else if (kind == 6)
                tgt = {22'h0, 8'($urandom_range(0, 255)),
                       2'($urandom_range(1, 3))};
            else if (kind == 7)
                tgt = $urandom | 32'h0000_0400;
            else if (kind == 8)
                tgt = 32'hFFFF_FFFC;
            else
                tgt = 32'h0000_03F0;
            cycle(rdy, rv, tgt);
        end

        // 6. asynchronous reset between edges
        cycle(1, 1, 32'h80);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'b0, id_valid}, 32'h0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_instr", id_instr, 32'h13);
        @(negedge clk);
        model_reset();
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("t6_hold", {31'b0, id_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0);
        chk("t6_pc", id_pc, 32'h0);
        chk("t6_i", id_instr, mem[0]);
        cycle(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
